// File: rtl/sc_gates_input_debouncer_pkg.sv
// Shared types and defaults for the two-channel gate-input debouncer.
package sc_gatesdeb_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;

  // Bit 1 of the encoding equals the accepted output level.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } deb_state_e;

endpackage

// File: rtl/sc_gates_input_debouncer_if.sv
// Raw-input / clean-output bundle between the switches, the debouncer and the gate block.
interface sc_gates_input_debouncer_if;
  logic SC_GATESDEB_a_InRaw;
  logic SC_GATESDEB_b_InRaw;
  logic SC_GATESDEB_a_Out;
  logic SC_GATESDEB_b_Out;
  logic SC_GATESDEB_aRise_Out;
  logic SC_GATESDEB_bRise_Out;
  logic SC_GATESDEB_busy_Out;

  modport master (
    output SC_GATESDEB_a_InRaw, SC_GATESDEB_b_InRaw,
    input  SC_GATESDEB_a_Out, SC_GATESDEB_b_Out,
    input  SC_GATESDEB_aRise_Out, SC_GATESDEB_bRise_Out,
    input  SC_GATESDEB_busy_Out
  );

  modport slave (
    input  SC_GATESDEB_a_InRaw, SC_GATESDEB_b_InRaw,
    output SC_GATESDEB_a_Out, SC_GATESDEB_b_Out,
    output SC_GATESDEB_aRise_Out, SC_GATESDEB_bRise_Out,
    output SC_GATESDEB_busy_Out
  );
endinterface

// File: rtl/sc_gates_input_debouncer_channel.sv
// One debounce channel: 2-flop synchroniser, counter FSM, registered level and
// optional rise pulse (enabled by SC_GATESDEB_EDGE_PULSE_EN).
module sc_debounce_channel
  import sc_gatesdeb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic busy
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             q1;
  logic             q2;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q1      <= 1'b0;
      q2      <= 1'b0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      q1      <= raw;
      q2      <= q1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    unique case (state_q)
      STABLE_LOW: begin
        if (q2) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!q2) begin
          state_d = STABLE_LOW;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HIGH;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HIGH: begin
        if (!q2) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (q2) begin
          state_d = STABLE_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LOW;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign level = level_q;
  assign busy  = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

`ifdef SC_GATESDEB_EDGE_PULSE_EN
  logic rise_q;

  // Registered alongside level_q so the pulse coincides with the first cycle level reads 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
    end else begin
      rise_q <= (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
    end
  end

  assign rise = rise_q;
`else
  assign rise = 1'b0;
`endif

endmodule

// File: rtl/sc_gates_input_debouncer.sv
// Two independent debounce channels feeding the gate block; rise pulses are
// present only when SC_GATESDEB_EDGE_PULSE_EN is defined (otherwise tied to 0).
module sc_gates_input_debouncer
  import sc_gatesdeb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                         SC_GATESDEB_CLOCK_50,
  input  logic                         SC_GATESDEB_RESET_InLow,
  sc_gates_input_debouncer_if.slave    deb
);

  logic busy_a;
  logic busy_b;

  sc_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk   (SC_GATESDEB_CLOCK_50),
    .rst_n (SC_GATESDEB_RESET_InLow),
    .raw   (deb.SC_GATESDEB_a_InRaw),
    .level (deb.SC_GATESDEB_a_Out),
    .rise  (deb.SC_GATESDEB_aRise_Out),
    .busy  (busy_a)
  );

  sc_debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk   (SC_GATESDEB_CLOCK_50),
    .rst_n (SC_GATESDEB_RESET_InLow),
    .raw   (deb.SC_GATESDEB_b_InRaw),
    .level (deb.SC_GATESDEB_b_Out),
    .rise  (deb.SC_GATESDEB_bRise_Out),
    .busy  (busy_b)
  );

  assign deb.SC_GATESDEB_busy_Out = busy_a | busy_b;

endmodule

// File: tb/tb_sc_gates_input_debouncer.sv
// Self-checking bench: run-length reference model feeds a per-cycle scoreboard; scenario tasks add targeted checks.
module tb_sc_gates_input_debouncer;

  localparam int unsigned N = 4;
`ifdef SC_GATESDEB_EDGE_PULSE_EN
  localparam logic PULSE_EN = 1'b1;
`else
  localparam logic PULSE_EN = 1'b0;
`endif

  typedef struct packed {
    logic a;
    logic b;
    logic a_rise;
    logic b_rise;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [1:0]  m_q1 = '0;
  logic [1:0]  m_q2 = '0;
  logic [1:0]  m_lvl = '0;
  logic [1:0]  m_rise = '0;
  int unsigned m_run[2] = '{0, 0};

  always #5 clk = ~clk;

  sc_gates_input_debouncer_if deb_if ();

  sc_gates_input_debouncer #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .SC_GATESDEB_CLOCK_50    (clk),
    .SC_GATESDEB_RESET_InLow (rst_n),
    .deb                     (deb_if)
  );

  // One clock: drive at negedge, advance model, push expectation, return #1 after posedge.
  task automatic tick(input logic ra, input logic rb, input logic rn);
    exp_t       e;
    logic [1:0] raw;
    @(negedge clk);
    deb_if.SC_GATESDEB_a_InRaw = ra;
    deb_if.SC_GATESDEB_b_InRaw = rb;
    rst_n = rn;
    raw = {rb, ra};
    if (!rn) begin
      m_q1 = '0; m_q2 = '0; m_lvl = '0; m_rise = '0;
      m_run[0] = 0; m_run[1] = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 1'b0;
        if (m_q2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == N + 1) begin
            m_lvl[c]  = m_q2[c];
            m_run[c]  = 0;
            m_rise[c] = m_q2[c] & PULSE_EN;
          end
        end else begin
          m_run[c] = 0;
        end
        m_q2[c] = m_q1[c];
        m_q1[c] = raw[c];
      end
    end
    e.a      = m_lvl[0];
    e.b      = m_lvl[1];
    e.a_rise = m_rise[0];
    e.b_rise = m_rise[1];
    e.busy   = (m_run[0] != 0) || (m_run[1] != 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks += 5;
      if (mon_e.a !== deb_if.SC_GATESDEB_a_Out) begin
        errors++; $display("FAIL sb_a_out t=%0t got=%b exp=%b", $time, deb_if.SC_GATESDEB_a_Out, mon_e.a);
      end
      if (mon_e.b !== deb_if.SC_GATESDEB_b_Out) begin
        errors++; $display("FAIL sb_b_out t=%0t got=%b exp=%b", $time, deb_if.SC_GATESDEB_b_Out, mon_e.b);
      end
      if (mon_e.a_rise !== deb_if.SC_GATESDEB_aRise_Out) begin
        errors++; $display("FAIL sb_a_rise t=%0t got=%b exp=%b", $time, deb_if.SC_GATESDEB_aRise_Out, mon_e.a_rise);
      end
      if (mon_e.b_rise !== deb_if.SC_GATESDEB_bRise_Out) begin
        errors++; $display("FAIL sb_b_rise t=%0t got=%b exp=%b", $time, deb_if.SC_GATESDEB_bRise_Out, mon_e.b_rise);
      end
      if (mon_e.busy !== deb_if.SC_GATESDEB_busy_Out) begin
        errors++; $display("FAIL sb_busy t=%0t got=%b exp=%b", $time, deb_if.SC_GATESDEB_busy_Out, mon_e.busy);
      end
    end
  end

  task automatic test_reset();
    logic [4:0] outs;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    outs = {deb_if.SC_GATESDEB_a_Out, deb_if.SC_GATESDEB_b_Out, deb_if.SC_GATESDEB_aRise_Out,
            deb_if.SC_GATESDEB_bRise_Out, deb_if.SC_GATESDEB_busy_Out};
    checks++;
    if (outs !== 5'b0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=00000", outs);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (i == 6) begin
        checks++;
        if (deb_if.SC_GATESDEB_a_Out !== 1'b0 || deb_if.SC_GATESDEB_b_Out !== 1'b0) begin
          errors++; $display("FAIL reset_release_early got=%b%b exp=00", deb_if.SC_GATESDEB_a_Out, deb_if.SC_GATESDEB_b_Out);
        end
      end
      if (i == 7) begin
        checks++;
        if (deb_if.SC_GATESDEB_a_Out !== 1'b1 || deb_if.SC_GATESDEB_b_Out !== 1'b1) begin
          errors++; $display("FAIL reset_release_accept got=%b%b exp=11", deb_if.SC_GATESDEB_a_Out, deb_if.SC_GATESDEB_b_Out);
        end
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (deb_if.SC_GATESDEB_a_Out !== 1'b0 || deb_if.SC_GATESDEB_busy_Out !== 1'b0) begin
      errors++; $display("FAIL reset_settle_low a=%b busy=%b exp a=0 busy=0", deb_if.SC_GATESDEB_a_Out, deb_if.SC_GATESDEB_busy_Out);
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      checks++;
      if (deb_if.SC_GATESDEB_a_Out !== (i >= 7)) begin
        errors++; $display("FAIL press_a_out tick=%0d got=%b exp=%b", i, deb_if.SC_GATESDEB_a_Out, (i >= 7));
      end
      checks++;
      if (deb_if.SC_GATESDEB_busy_Out !== (i >= 3 && i <= 6)) begin
        errors++; $display("FAIL press_busy tick=%0d got=%b exp=%b", i, deb_if.SC_GATESDEB_busy_Out, (i >= 3 && i <= 6));
      end
      checks++;
      if (deb_if.SC_GATESDEB_aRise_Out !== ((i == 7) & PULSE_EN)) begin
        errors++; $display("FAIL press_a_rise tick=%0d got=%b exp=%b", i, deb_if.SC_GATESDEB_aRise_Out, ((i == 7) & PULSE_EN));
      end
      checks++;
      if (deb_if.SC_GATESDEB_b_Out !== 1'b0) begin
        errors++; $display("FAIL press_b_quiet tick=%0d got=%b exp=0", i, deb_if.SC_GATESDEB_b_Out);
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_glitch();
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, (i <= 3), 1'b1);
      checks++;
      if (deb_if.SC_GATESDEB_b_Out !== 1'b0 || deb_if.SC_GATESDEB_bRise_Out !== 1'b0) begin
        errors++; $display("FAIL glitch_b tick=%0d out=%b rise=%b exp 0/0", i, deb_if.SC_GATESDEB_b_Out, deb_if.SC_GATESDEB_bRise_Out);
      end
    end
    checks++;
    if (deb_if.SC_GATESDEB_busy_Out !== 1'b0) begin
      errors++; $display("FAIL glitch_busy_idle got=%b exp=0", deb_if.SC_GATESDEB_busy_Out);
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b10101;
    for (int i = 1; i <= 12; i++) begin
      tick((i > 5) ? 1'b1 : pat[5 - i], 1'b0, 1'b1);
      if (i == 10 || i == 11) begin
        checks++;
        if (deb_if.SC_GATESDEB_a_Out !== (i == 11)) begin
          errors++; $display("FAIL bounce_a_out tick=%0d got=%b exp=%b", i, deb_if.SC_GATESDEB_a_Out, (i == 11));
        end
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 1; i <= 9; i++) begin
        tick(ph == 0, ph == 0, 1'b1);
        checks++;
        if (deb_if.SC_GATESDEB_a_Out !== deb_if.SC_GATESDEB_b_Out ||
            deb_if.SC_GATESDEB_aRise_Out !== deb_if.SC_GATESDEB_bRise_Out) begin
          errors++; $display("FAIL simul_match tick=%0d a=%b b=%b ar=%b br=%b exp equal", i, deb_if.SC_GATESDEB_a_Out,
                             deb_if.SC_GATESDEB_b_Out, deb_if.SC_GATESDEB_aRise_Out, deb_if.SC_GATESDEB_bRise_Out);
        end
        if (i == 7) begin
          checks++;
          if (deb_if.SC_GATESDEB_a_Out !== (ph == 0) || deb_if.SC_GATESDEB_aRise_Out !== ((ph == 0) & PULSE_EN)) begin
            errors++; $display("FAIL simul_accept ph=%0d a=%b rise=%b exp a=%b", ph, deb_if.SC_GATESDEB_a_Out,
                               deb_if.SC_GATESDEB_aRise_Out, (ph == 0));
          end
        end
      end
    end
  endtask

  task automatic test_reset_midcount();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    checks++;
    if (deb_if.SC_GATESDEB_a_Out !== 1'b0 || deb_if.SC_GATESDEB_busy_Out !== 1'b0) begin
      errors++; $display("FAIL midcount_abort a=%b busy=%b exp 0/0", deb_if.SC_GATESDEB_a_Out, deb_if.SC_GATESDEB_busy_Out);
    end
    for (int i = 1; i <= 7; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (i >= 6) begin
        checks++;
        if (deb_if.SC_GATESDEB_a_Out !== (i == 7)) begin
          errors++; $display("FAIL midcount_relatch tick=%0d got=%b exp=%b", i, deb_if.SC_GATESDEB_a_Out, (i == 7));
        end
      end
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic ra, rb;
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) ra = ~ra;
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      tick(ra, rb, ($urandom_range(0, 79) != 0));
    end
  endtask

  initial begin
    deb_if.SC_GATESDEB_a_InRaw = 1'b0;
    deb_if.SC_GATESDEB_b_InRaw = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_midcount();
    test_random();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain left=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
